imem_arb: RTL and testbench
===========================

IMEM_ARB -- requirements
Module: imem_arb

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, meaning the number of consecutive denied debug-request cycles before the debug port is forced a grant (legal range 1..15).
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port clr  input  1  reset, synchronous and active-low: sampled on rising clk, asserted when 0.
REQ-004 SHALL have port f_req  input  1  fetch-port read request.
REQ-005 SHALL have port f_addr  input  16  fetch-port read address.
REQ-006 SHALL have port f_gnt  output  1  fetch request accepted this cycle (combinational).
REQ-007 SHALL have port f_rvalid  output  1  fetch read data valid (registered).
REQ-008 SHALL have port f_rdata  output  32  fetch read data (registered).
REQ-009 SHALL have ports d_req, d_addr, d_gnt, d_rvalid, d_rdata, with the same directions, widths and meanings as the fetch ports, for the debug port.
REQ-010 SHALL have port halt  input  1  core halted; the fetch port is blocked while it is 1.
REQ-011 SHALL have port mem_cs  output  1  instruction-memory chip select.
REQ-012 SHALL have port mem_addr  output  16  instruction-memory address.
REQ-013 SHALL have port mem_rdata  input  32  instruction-memory read data, combinational from mem_addr.
REQ-014 SHALL have port starve_cnt  output  4  current starvation count (registered).

Function
REQ-015 SHALL grant at most one port per cycle; f_gnt and d_gnt SHALL never both be 1.
REQ-016 SHALL grant by default priority: fetch over debug.
REQ-017 SHALL grant debug and deny fetch whenever halt=1.
REQ-018 SHALL, with the starvation guard active and starve_cnt==STARVE_LIMIT, grant debug over fetch for exactly one cycle.
REQ-019 SHALL drive mem_cs=1 and mem_addr=the granted port's address in the grant cycle; with no grant, mem_cs=0 and mem_addr=16'h0000.
REQ-020 SHALL capture mem_rdata into the granted port's rdata and pulse that port's rvalid for one cycle on the edge ending the grant cycle (latency 1); the other port's rdata SHALL hold.
REQ-021 SHALL support back-to-back grants every cycle with no bubble.
REQ-022 SHALL increment starve_cnt on each cycle d_req=1 and d_gnt=0, saturating at STARVE_LIMIT, and clear it to 0 on a d_gnt cycle or when d_req=0.
REQ-023 SHALL treat requests as non-sticky: a denied request is not queued; the requester holds req and addr until gnt.
REQ-024 SHALL track internal state REG (IDLE, F_OWN, D_OWN) = the owner of the last grant; F_OWN or D_OWN SHALL return to IDLE on a no-grant cycle.

Reset
REQ-025 SHALL, while clr=0, force f_gnt=d_gnt=0, mem_cs=0 and mem_addr=16'h0000 combinationally.
REQ-026 SHALL set f_rvalid=d_rvalid=0, f_rdata=d_rdata=32'h0, starve_cnt=0 and state=IDLE on the first edge with clr=0.
REQ-027 SHALL drop, not deliver, a response whose grant cycle coincides with clr=0.

Configuration
REQ-028 SHALL compile in the starvation guard (REQ-018, REQ-022) only when IMEM_ARB_STARVE_EN is defined.
REQ-029 SHALL, without IMEM_ARB_STARVE_EN, use pure fixed priority (REQ-016, REQ-017) and tie starve_cnt to 0.

Verification
REQ-030 SHALL cover: f_req=1 f_addr=0x0010, d_req=0 -> f_gnt=1, mem_addr=0x0010, next cycle f_rvalid=1 and f_rdata=ROM[0x0010].
REQ-031 SHALL cover: f_req and d_req both held 1, halt=0, guard on, STARVE_LIMIT=4 -> f_gnt for 4 cycles, d_gnt in cycle 5, starve_cnt sequence 1,2,3,4,0.
REQ-032 SHALL cover: the same stimulus as REQ-031 with the guard compiled out -> d_gnt never 1 and starve_cnt=0 throughout.
REQ-033 SHALL cover: halt=1, f_req=d_req=1, d_addr=0x0020 -> d_gnt=1, f_gnt=0, next cycle d_rdata=ROM[0x0020].
REQ-034 SHALL cover: clr=0 asserted in a grant cycle -> no rvalid on the following cycle, all outputs at reset values, mem_addr=0x0000.
REQ-035 SHALL cover: alternating f_addr 0x0000,0x0004,0x0008 on consecutive cycles -> three consecutive f_rvalid pulses with matching ROM data.

Source files
------------

// File: rtl/imem_arb.sv
// Two-port (fetch, debug) instruction-memory arbiter; optional debug starvation guard via IMEM_ARB_STARVE_EN.
// Grant is combinational, read data returns 1 cycle later; no backpressure, denied requests are not queued.
module imem_arb #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        f_req,
  input  logic [15:0] f_addr,
  output logic        f_gnt,
  output logic        f_rvalid,
  output logic [31:0] f_rdata,
  input  logic        d_req,
  input  logic [15:0] d_addr,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  input  logic        halt,
  output logic        mem_cs,
  output logic [15:0] mem_addr,
  input  logic [31:0] mem_rdata,
  output logic [3:0]  starve_cnt
);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
    $error("imem_arb: STARVE_LIMIT must be within 1..15");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    F_OWN = 2'd1,
    D_OWN = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        f_rvalid_q, f_rvalid_d;
  logic        d_rvalid_q, d_rvalid_d;
  logic [31:0] f_rdata_q, f_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        f_gnt_c, d_gnt_c;
  logic        starve_force;

`ifdef IMEM_ARB_STARVE_EN
  localparam logic [3:0] LIMIT = STARVE_LIMIT[3:0];

  logic [3:0] starve_cnt_q, starve_cnt_d;

  assign starve_force = (starve_cnt_q == LIMIT);
  assign starve_cnt   = starve_cnt_q;

  // Count only cycles where debug asks and loses; any debug grant or idle debug resets.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!d_req || d_gnt_c) begin
      starve_cnt_d = 4'd0;
    end else if (starve_cnt_q != LIMIT) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      starve_cnt_q <= 4'd0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end
`else
  assign starve_force = 1'b0;
  assign starve_cnt   = 4'd0;
`endif

  // Halt blocks fetch outright; reset suppresses every grant in the same cycle.
  always_comb begin
    f_gnt_c = 1'b0;
    d_gnt_c = 1'b0;
    if (clr) begin
      if (halt) begin
        d_gnt_c = d_req;
      end else if (starve_force && d_req) begin
        d_gnt_c = 1'b1;
      end else if (f_req) begin
        f_gnt_c = 1'b1;
      end else if (d_req) begin
        d_gnt_c = 1'b1;
      end
    end
  end

  assign f_gnt  = f_gnt_c;
  assign d_gnt  = d_gnt_c;
  assign mem_cs = f_gnt_c | d_gnt_c;

  always_comb begin
    mem_addr = 16'h0000;
    if (f_gnt_c) begin
      mem_addr = f_addr;
    end else if (d_gnt_c) begin
      mem_addr = d_addr;
    end
  end

  always_comb begin
    f_rvalid_d = f_gnt_c;
    d_rvalid_d = d_gnt_c;
    f_rdata_d  = f_gnt_c ? mem_rdata : f_rdata_q;
    d_rdata_d  = d_gnt_c ? mem_rdata : d_rdata_q;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (f_gnt_c)      state_d = F_OWN;
        else if (d_gnt_c) state_d = D_OWN;
      end
      F_OWN: begin
        if (d_gnt_c)      state_d = D_OWN;
        else if (!f_gnt_c) state_d = IDLE;
      end
      D_OWN: begin
        if (f_gnt_c)      state_d = F_OWN;
        else if (!d_gnt_c) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q    <= IDLE;
      f_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      f_rdata_q  <= 32'h0;
      d_rdata_q  <= 32'h0;
    end else begin
      state_q    <= state_d;
      f_rvalid_q <= f_rvalid_d;
      d_rvalid_q <= d_rvalid_d;
      f_rdata_q  <= f_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  assign f_rvalid = f_rvalid_q;
  assign d_rvalid = d_rvalid_q;
  assign f_rdata  = f_rdata_q;
  assign d_rdata  = d_rdata_q;

endmodule

// File: tb/tb_imem_arb.sv
// Directed bench for imem_arb with a behavioural ROM on the memory side.
module tb_imem_arb;

  logic        clk;
  logic        clr;
  logic        f_req, d_req, halt;
  logic [15:0] f_addr, d_addr;
  logic        f_gnt, d_gnt, f_rvalid, d_rvalid, mem_cs;
  logic [31:0] f_rdata, d_rdata, mem_rdata;
  logic [15:0] mem_addr;
  logic [3:0]  starve_cnt;

  int passed = 0;
  int total  = 0;

  imem_arb #(.STARVE_LIMIT(4)) dut (
    .clk       (clk),
    .clr       (clr),
    .f_req     (f_req),
    .f_addr    (f_addr),
    .f_gnt     (f_gnt),
    .f_rvalid  (f_rvalid),
    .f_rdata   (f_rdata),
    .d_req     (d_req),
    .d_addr    (d_addr),
    .d_gnt     (d_gnt),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata),
    .halt      (halt),
    .mem_cs    (mem_cs),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .starve_cnt(starve_cnt)
  );

  function automatic logic [31:0] rom(input logic [15:0] a);
    return {a ^ 16'hA5C3, ~a};
  endfunction

  assign mem_rdata = rom(mem_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  logic [3:0] exp_cnt [5];
  logic       exp_dg  [5];

  initial begin
`ifdef IMEM_ARB_STARVE_EN
    exp_cnt = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
    exp_dg  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
`else
    exp_cnt = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    exp_dg  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
    clr = 1'b0; f_req = 1'b0; d_req = 1'b0; halt = 1'b0;
    f_addr = 16'h0; d_addr = 16'h0;
    step();
    step();

    // reset state, and grants suppressed while clr=0
    f_req = 1'b1; f_addr = 16'h0010;
    settle();
    chk("rst_f_gnt", {31'b0, f_gnt}, 32'd0);
    chk("rst_mem_cs", {31'b0, mem_cs}, 32'd0);
    chk("rst_mem_addr", {16'b0, mem_addr}, 32'h0);
    chk("rst_f_rvalid", {31'b0, f_rvalid}, 32'd0);
    chk("rst_d_rvalid", {31'b0, d_rvalid}, 32'd0);
    chk("rst_f_rdata", f_rdata, 32'h0);
    chk("rst_d_rdata", d_rdata, 32'h0);
    chk("rst_starve", {28'b0, starve_cnt}, 32'd0);

    // single fetch at 0x0010
    clr = 1'b1;
    settle();
    chk("f1_gnt", {31'b0, f_gnt}, 32'd1);
    chk("f1_dgnt", {31'b0, d_gnt}, 32'd0);
    chk("f1_cs", {31'b0, mem_cs}, 32'd1);
    chk("f1_addr", {16'b0, mem_addr}, 32'h0010);
    step();
    f_req = 1'b0;
    chk("f1_rvalid", {31'b0, f_rvalid}, 32'd1);
    chk("f1_rdata", f_rdata, rom(16'h0010));
    chk("f1_d_rvalid", {31'b0, d_rvalid}, 32'd0);
    settle();
    chk("idle_cs", {31'b0, mem_cs}, 32'd0);
    chk("idle_addr", {16'b0, mem_addr}, 32'h0);
    step();
    chk("f1_rvalid_drop", {31'b0, f_rvalid}, 32'd0);
    chk("f1_rdata_hold", f_rdata, rom(16'h0010));

    // back-to-back fetches 0x0000, 0x0004, 0x0008
    f_req = 1'b1; f_addr = 16'h0000;
    step();
    chk("b2b0_rvalid", {31'b0, f_rvalid}, 32'd1);
    chk("b2b0_rdata", f_rdata, rom(16'h0000));
    f_addr = 16'h0004;
    step();
    chk("b2b1_rvalid", {31'b0, f_rvalid}, 32'd1);
    chk("b2b1_rdata", f_rdata, rom(16'h0004));
    f_addr = 16'h0008;
    step();
    chk("b2b2_rvalid", {31'b0, f_rvalid}, 32'd1);
    chk("b2b2_rdata", f_rdata, rom(16'h0008));
    f_req = 1'b0;
    step();
    chk("b2b_end_rvalid", {31'b0, f_rvalid}, 32'd0);
    chk("b2b_d_rdata_hold", d_rdata, 32'h0);

    // halt: debug wins, fetch blocked
    halt = 1'b1; f_req = 1'b1; d_req = 1'b1; f_addr = 16'h0030; d_addr = 16'h0020;
    settle();
    chk("halt_dgnt", {31'b0, d_gnt}, 32'd1);
    chk("halt_fgnt", {31'b0, f_gnt}, 32'd0);
    chk("halt_addr", {16'b0, mem_addr}, 32'h0020);
    step();
    d_req = 1'b0;
    chk("halt_d_rvalid", {31'b0, d_rvalid}, 32'd1);
    chk("halt_d_rdata", d_rdata, rom(16'h0020));
    chk("halt_f_rvalid", {31'b0, f_rvalid}, 32'd0);
    chk("halt_f_rdata_hold", f_rdata, rom(16'h0008));
    settle();
    chk("halt_nodreq_cs", {31'b0, mem_cs}, 32'd0);
    chk("halt_nodreq_fgnt", {31'b0, f_gnt}, 32'd0);
    halt = 1'b0; f_req = 1'b0;
    step();

    // contention: both requesting, halt=0
    f_req = 1'b1; d_req = 1'b1; f_addr = 16'h0040; d_addr = 16'h0044;
    for (int i = 0; i < 5; i++) begin
      settle();
      chk($sformatf("starve_dgnt_c%0d", i + 1), {31'b0, d_gnt}, {31'b0, exp_dg[i]});
      chk($sformatf("starve_fgnt_c%0d", i + 1), {31'b0, f_gnt}, {31'b0, ~exp_dg[i]});
      step();
      chk($sformatf("starve_cnt_c%0d", i + 1), {28'b0, starve_cnt}, {28'b0, exp_cnt[i]});
    end
`ifdef IMEM_ARB_STARVE_EN
    chk("starve_d_rvalid", {31'b0, d_rvalid}, 32'd1);
    chk("starve_d_rdata", d_rdata, rom(16'h0044));
`else
    chk("starve_d_rvalid", {31'b0, d_rvalid}, 32'd0);
    chk("starve_f_rdata", f_rdata, rom(16'h0040));
`endif

    // reset in a grant cycle after building some state
    d_req = 1'b0;
    step();
    d_req = 1'b1; f_addr = 16'h0050;
    step();
    clr = 1'b0;
    settle();
    chk("clr_fgnt", {31'b0, f_gnt}, 32'd0);
    chk("clr_dgnt", {31'b0, d_gnt}, 32'd0);
    chk("clr_cs", {31'b0, mem_cs}, 32'd0);
    chk("clr_addr", {16'b0, mem_addr}, 32'h0);
    step();
    chk("clr_f_rvalid", {31'b0, f_rvalid}, 32'd0);
    chk("clr_d_rvalid", {31'b0, d_rvalid}, 32'd0);
    chk("clr_f_rdata", f_rdata, 32'h0);
    chk("clr_d_rdata", d_rdata, 32'h0);
    chk("clr_starve", {28'b0, starve_cnt}, 32'd0);

    clr = 1'b1; f_req = 1'b0; d_req = 1'b0;
    step();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
